countdown_timer: RTL and testbench

Loadable down-counting timer with one-shot and periodic modes, a one-cycle expiry pulse and pause/stop control. It is the complement of the up counter already in the library: it counts toward zero from a programmed value. HIL stimulus logic uses it to schedule events after a programmed delay or at a fixed rate. It sits beside the other counter primitives in the shared library and is driven directly by control registers or sequencer FSMs.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding and state width.
// Latency: n/a (package only).
// Backpressure: n/a.
package countdown_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] STATE_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] STATE_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] STATE_HOLD = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = STATE_IDLE,
        S_RUN  = STATE_RUN,
        S_HOLD = STATE_HOLD
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a tick every divider+1 consumed cycles.
// Latency: tick is combinational from the internal counter; counter advances one step per non-held cycle.
// Backpressure: hold freezes the counter (tick stays visible); clear restarts the division from zero.
// Ports: clk, reset (sync, active-high), clear, hold, divider[W], tick.
module tick_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         hold,
    input  logic [W-1:0] divider,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == divider);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer, one-shot or periodic, with one-cycle expiry pulse and pause/stop control.
// Latency: count = load_value one edge after start; expiry pulse (L+1)*(P+1) edges after start (P=0 without prescaler).
// Backpressure: pause (level) freezes the count and prescaler; stop aborts to idle; start restarts at any time.
// Ports: clk, reset, start, stop, pause, periodic, load_value[WIDTH], prescale[PRESCALE_WIDTH] -> count[WIDTH], busy, expired.
// Optional feature: define COUNTDOWN_PRESCALER_EN to build the tick prescaler; otherwise every cycle is a tick.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      periodic,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      busy,
    output logic                      expired
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic             tick;
    logic             consume;

    // A cycle may consume a tick when active and not paused. In RUN the
    // expiry still wins over a pause that arrives in the same cycle.
    assign consume = (state_q != S_IDLE) &&
                     (!pause || ((state_q == S_RUN) && (count_q == '0)));

`ifdef COUNTDOWN_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
        end else if (start && !stop) begin
            prescale_q <= prescale;
        end
    end

    tick_prescaler #(.W(PRESCALE_WIDTH)) u_tick_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (start || stop),
        .hold    (!consume),
        .divider (prescale_q),
        .tick    (tick)
    );
`else
    logic prescale_unused;
    assign prescale_unused = ^prescale;
    assign tick            = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (start) begin
            reload_d   = load_value;
            periodic_d = periodic;
            count_d    = load_value;
            state_d    = S_RUN;
        end else if (state_q != S_IDLE) begin
            if (consume && tick) begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    expired_d = 1'b1;
                    if (periodic_q) begin
                        count_d = reload_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            // Pause only decides RUN vs HOLD for the next cycle.
            if (state_d != S_IDLE) begin
                state_d = pause ? S_HOLD : S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q != S_IDLE);
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios plus randomized run against a behavioural model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic [7:0] prescale = 8'd0;
    logic [7:0] count;
    logic       busy;
    logic       expired;

    int vec = 0;
    int miscmp = 0;

    // Behavioural model: remaining value, whether active, and whether the
    // previous cycle left the timer frozen by pause.
    logic       m_busy = 1'b0;
    logic       m_exp = 1'b0;
    logic       m_held = 1'b0;
    logic       m_per = 1'b0;
    logic [7:0] m_count = 8'd0;
    logic [7:0] m_reload = 8'd0;

    countdown_timer #(.WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .periodic   (periodic),
        .load_value (load_value),
        .prescale   (prescale),
        .count      (count),
        .busy       (busy),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_count = 0; m_exp = 0; m_held = 0; m_reload = 0; m_per = 0;
        end else if (stop) begin
            m_busy = 0; m_count = 0; m_exp = 0; m_held = 0;
        end else if (start) begin
            m_busy = 1; m_count = load_value; m_reload = load_value;
            m_per = periodic; m_exp = 0; m_held = 0;
        end else begin
            m_exp = 0;
            if (m_busy) begin
                if (!pause || (!m_held && m_count == 0)) begin
                    if (m_count > 0) m_count = m_count - 1;
                    else begin
                        m_exp = 1;
                        if (m_per) m_count = m_reload;
                        else m_busy = 0;
                    end
                end
                m_held = m_busy && pause;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; periodic = 0; load_value = 0; prescale = 0; reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; step(); step();
        vec++; if ({busy, expired, count} !== 10'h000) begin miscmp++;
            $display("FAIL reset_init: got %h want %h", {busy, expired, count}, 10'h000); end
        idle_inputs();
        start = 1; load_value = 8'd5; step(); start = 0;
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd5}) begin miscmp++;
            $display("FAIL reset_prerun: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd5}); end
        reset = 1; step(); reset = 0;
        vec++; if ({busy, expired, count} !== 10'h000) begin miscmp++;
            $display("FAIL reset_midrun: got %h want %h", {busy, expired, count}, 10'h000); end
        step();
        vec++; if ({busy, expired, count} !== 10'h000) begin miscmp++;
            $display("FAIL reset_stays_idle: got %h want %h", {busy, expired, count}, 10'h000); end
    endtask

    task automatic test_oneshot();
        logic [9:0] want;
        idle_inputs();
        start = 1; load_value = 8'd3; step(); idle_inputs();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd3}) begin miscmp++;
            $display("FAIL oneshot_e0: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd3}); end
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e <= 3) want = {1'b1, 1'b0, 8'(3 - e)};
            else if (e == 4) want = {1'b0, 1'b1, 8'd0};
            else want = 10'h000;
            vec++; if ({busy, expired, count} !== want) begin miscmp++;
                $display("FAIL oneshot_e%0d: got %h want %h", e, {busy, expired, count}, want); end
        end
    endtask

    task automatic test_periodic();
        idle_inputs();
        start = 1; periodic = 1; load_value = 8'd2; step(); idle_inputs();
        for (int e = 1; e <= 9; e++) begin
            step();
            vec++; if (expired !== (e % 3 == 0) || busy !== 1'b1) begin miscmp++;
                $display("FAIL periodic_e%0d: got exp=%0b busy=%0b want exp=%0b busy=1",
                         e, expired, busy, (e % 3 == 0)); end
        end
        step();
        vec++; if (count !== 8'd1) begin miscmp++;
            $display("FAIL periodic_cnt1: got %0d want 1", count); end
        stop = 1; step(); stop = 0;
        vec++; if ({busy, expired, count} !== 10'h000) begin miscmp++;
            $display("FAIL periodic_stop: got %h want %h", {busy, expired, count}, 10'h000); end
        for (int e = 0; e < 6; e++) begin
            step();
            vec++; if ({busy, expired} !== 2'b00) begin miscmp++;
                $display("FAIL periodic_after_stop_%0d: got %b want 00", e, {busy, expired}); end
        end
    endtask

    task automatic test_pause();
        int seen;
        idle_inputs();
        start = 1; load_value = 8'd9; step(); idle_inputs();
        for (int e = 0; e < 4; e++) step();
        vec++; if (count !== 8'd5) begin miscmp++;
            $display("FAIL pause_pre: got %0d want 5", count); end
        pause = 1;
        for (int e = 0; e < 4; e++) begin
            step();
            vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd5}) begin miscmp++;
                $display("FAIL pause_hold_%0d: got %h want %h", e, {busy, expired, count}, {1'b1, 1'b0, 8'd5}); end
        end
        pause = 0;
        // Unpaused expiry would be 10 edges after start; pause adds 4 -> edge 14, i.e. 6 more.
        seen = -1;
        for (int e = 1; e <= 20 && seen < 0; e++) begin
            step();
            if (expired === 1'b1) seen = e;
        end
        vec++; if (seen != 6) begin miscmp++;
            $display("FAIL pause_delay: got %0d edges want 6", seen); end
    endtask

    task automatic test_zero_and_restart();
        idle_inputs();
        start = 1; load_value = 8'd0; step(); idle_inputs();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd0}) begin miscmp++;
            $display("FAIL zero_e0: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd0}); end
        step();
        vec++; if ({busy, expired, count} !== {1'b0, 1'b1, 8'd0}) begin miscmp++;
            $display("FAIL zero_e1: got %h want %h", {busy, expired, count}, {1'b0, 1'b1, 8'd0}); end
        start = 1; periodic = 1; load_value = 8'd4; step(); idle_inputs();
        for (int e = 0; e < 4; e++) step();
        vec++; if (count !== 8'd0 || expired !== 1'b0) begin miscmp++;
            $display("FAIL restart_pre: got cnt=%0d exp=%0b want 0 0", count, expired); end
        start = 1; periodic = 1; load_value = 8'd7; step(); idle_inputs();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd7}) begin miscmp++;
            $display("FAIL restart_at_expiry: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd7}); end
        step();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd6}) begin miscmp++;
            $display("FAIL restart_next: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd6}); end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_expiry_vs_pause();
        idle_inputs();
        start = 1; periodic = 1; load_value = 8'd1; step(); idle_inputs();
        step();
        pause = 1; step();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b1, 8'd1}) begin miscmp++;
            $display("FAIL exp_vs_pause: got %h want %h", {busy, expired, count}, {1'b1, 1'b1, 8'd1}); end
        step();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd1}) begin miscmp++;
            $display("FAIL exp_vs_pause_hold: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd1}); end
        pause = 0; step();
        vec++; if ({busy, expired, count} !== {1'b1, 1'b0, 8'd0}) begin miscmp++;
            $display("FAIL exp_vs_pause_resume: got %h want %h", {busy, expired, count}, {1'b1, 1'b0, 8'd0}); end
        stop = 1; step(); stop = 0;
    endtask

`ifdef COUNTDOWN_PRESCALER_EN
    task automatic test_prescaler();
        logic [9:0] want;
        idle_inputs();
        start = 1; load_value = 8'd1; prescale = 8'd2; step(); idle_inputs();
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 3) want = {1'b1, 1'b0, 8'd1};
            else if (e < 6) want = {1'b1, 1'b0, 8'd0};
            else if (e == 6) want = {1'b0, 1'b1, 8'd0};
            else want = 10'h000;
            vec++; if ({busy, expired, count} !== want) begin miscmp++;
                $display("FAIL prescale_e%0d: got %h want %h", e, {busy, expired, count}, want); end
        end
    endtask
`endif

    task automatic test_random();
        int r;
        idle_inputs();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            start = (r < 6);
            stop = (r >= 6 && r < 9);
            reset = (r == 99);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            periodic = 1'($urandom_range(0, 1));
            load_value = 8'($urandom_range(0, 6));
            prescale = 8'd0;
            step();
            vec++; if ({busy, expired, count} !== {m_busy, m_exp, m_count}) begin miscmp++;
                $display("FAIL random_%0d: got %h want %h", i, {busy, expired, count}, {m_busy, m_exp, m_count}); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_zero_and_restart();
        test_expiry_vs_pause();
`ifdef COUNTDOWN_PRESCALER_EN
        test_prescaler();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
